// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit for the 8-bit ALU/register-file datapath.
// Fetches over a req/valid handshake, then decodes, executes and writes back.
module alu_ctrl_fsm #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [7:0]      imem_data_i,
  output logic [1:0]      rf_raddr1_o,
  output logic [1:0]      rf_raddr2_o,
  output logic            rf_we_o,
  output logic [1:0]      rf_waddr_o,
  output logic [1:0]      alu_op_o,
  output logic            imm_sel_o,
  output logic [1:0]      imm2_o,
  input  logic            alu_zero_i,
  output logic [PC_W-1:0] pc_o,
  output logic            z_flag_o,
  output logic            halted_o
);

  // state   | meaning
  // S_FETCH | request imem[pc], wait for valid, latch ir
  // S_EXEC  | ALU op: drive controls; branch/jump/nop: update pc
  // S_WB    | write rd, latch zero flag, pc+1
  // S_HALT  | idle until reset
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_e;

  localparam logic [1:0] OP_NULL = 2'b11;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic            z_q;
  logic            req_q;
  logic            halted_q;
  logic            rf_we_q;
  logic [1:0]      rf_waddr_q;
  logic [1:0]      raddr1_q;
  logic [1:0]      raddr2_q;
  logic [1:0]      alu_op_q;
  logic            imm_sel_q;
  logic [1:0]      imm2_q;

  logic [2:0]      data_op;
  logic            data_is_alu;
  logic [2:0]      ir_op;
  logic            ir_is_alu;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  assign data_op     = imem_data_i[7:5];
  assign data_is_alu = (data_op < 3'd3);
  assign ir_op       = ir_q[7:5];
  assign ir_is_alu   = (ir_op < 3'd3);
  assign pc_inc      = pc_q + PC_W'(1);
  // Offset is sign-extended so backward branches wrap modulo 2^PC_W.
  assign br_target   = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
  assign jmp_target  = {{(PC_W-5){1'b0}}, ir_q[4:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      z_q        <= 1'b0;
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      alu_op_q   <= OP_NULL;
      imm_sel_q  <= 1'b0;
      imm2_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          req_q <= 1'b1;
          // Only accept data against a request we are actually driving.
          if (req_q && imem_valid_i) begin
            ir_q    <= imem_data_i;
            req_q   <= 1'b0;
            state_q <= S_EXEC;
            if (data_is_alu) begin
              alu_op_q  <= data_op[1:0];
              raddr1_q  <= imem_data_i[4:3];
              raddr2_q  <= imem_data_i[2:1];
              imm_sel_q <= imem_data_i[0];
              imm2_q    <= imem_data_i[2:1];
            end
          end
        end
        S_EXEC: begin
          if (ir_is_alu) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= ir_q[4:3];
            state_q    <= S_WB;
          end else if (ir_op == 3'b111) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            case (ir_op)
              3'b100:  pc_q <= z_q ? br_target : pc_inc;
              3'b101:  pc_q <= jmp_target;
              default: pc_q <= pc_inc;
            endcase
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          z_q        <= alu_zero_i;
          pc_q       <= pc_inc;
          rf_we_q    <= 1'b0;
          rf_waddr_q <= '0;
          raddr1_q   <= '0;
          raddr2_q   <= '0;
          alu_op_q   <= OP_NULL;
          imm_sel_q  <= 1'b0;
          imm2_q     <= '0;
          req_q      <= 1'b1;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign z_flag_o    = z_q;
  assign halted_o    = halted_q;
  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_raddr1_o = raddr1_q;
  assign rf_raddr2_o = raddr2_q;
  assign alu_op_o    = alu_op_q;
  assign imm_sel_o   = imm_sel_q;
  assign imm2_o      = imm2_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: a table of instructions with hand-computed
// controls/pc/z_flag, plus hand-written reset, wait and halt sequences.
module tb_alu_ctrl_fsm;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       imem_req_o;
  logic [7:0] imem_addr_o;
  logic       imem_valid_i;
  logic [7:0] imem_data_i;
  logic [1:0] rf_raddr1_o, rf_raddr2_o, rf_waddr_o, alu_op_o, imm2_o;
  logic       rf_we_o, imm_sel_o, alu_zero_i, z_flag_o, halted_o;
  logic [7:0] pc_o;

  int total = 0;
  int bad   = 0;

  alu_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .alu_op_o(alu_op_o), .imm_sel_o(imm_sel_o), .imm2_o(imm2_o),
    .alu_zero_i(alu_zero_i), .pc_o(pc_o), .z_flag_o(z_flag_o),
    .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] instr;
    int         nwait;
    logic [7:0] pc_in;
    logic       zero_in;
    logic       is_alu;
    logic [1:0] op;
    logic [1:0] ra1;
    logic [1:0] ra2;
    logic       isel;
    logic [1:0] imm2;
    logic [7:0] pc_out;
    logic       z_out;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Entry: DUT in FETCH with req high. Exit: DUT in EXEC.
  task automatic fetch(input logic [7:0] instr, input int nwait, input logic [7:0] pc_exp);
    for (int k = 0; k < nwait; k++) begin
      chk("wait_req", int'(imem_req_o), 1);
      chk("wait_addr", int'(imem_addr_o), int'(pc_exp));
      step();
    end
    imem_valid_i = 1'b1;
    imem_data_i  = instr;
    chk("fetch_req", int'(imem_req_o), 1);
    chk("fetch_addr", int'(imem_addr_o), int'(pc_exp));
    step();
    imem_valid_i = 1'b0;
    imem_data_i  = 8'h00;
  endtask

  task automatic run_vec(input vec_t v);
    fetch(v.instr, v.nwait, v.pc_in);
    chk("exec_req", int'(imem_req_o), 0);
    chk("exec_we", int'(rf_we_o), 0);
    chk("exec_op", int'(alu_op_o), int'(v.op));
    chk("exec_ra1", int'(rf_raddr1_o), int'(v.ra1));
    chk("exec_ra2", int'(rf_raddr2_o), int'(v.ra2));
    chk("exec_isel", int'(imm_sel_o), int'(v.isel));
    chk("exec_imm2", int'(imm2_o), int'(v.imm2));
    if (v.is_alu) begin
      step();
      alu_zero_i = v.zero_in;
      chk("wb_we", int'(rf_we_o), 1);
      chk("wb_waddr", int'(rf_waddr_o), int'(v.ra1));
      chk("wb_op", int'(alu_op_o), int'(v.op));
      chk("wb_ra2", int'(rf_raddr2_o), int'(v.ra2));
      chk("wb_isel", int'(imm_sel_o), int'(v.isel));
      chk("wb_imm2", int'(imm2_o), int'(v.imm2));
      chk("wb_pc", int'(pc_o), int'(v.pc_in));
    end
    step();
    alu_zero_i = 1'b0;
    chk("post_pc", int'(pc_o), int'(v.pc_out));
    chk("post_z", int'(z_flag_o), int'(v.z_out));
    chk("post_req", int'(imem_req_o), 1);
    chk("post_we", int'(rf_we_o), 0);
    chk("post_op", int'(alu_op_o), 3);
    chk("post_halt", int'(halted_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            instr  wt pc_in zero alu op ra1 ra2 isel imm2 pc_out z
    vecs[0]  = '{8'h34, 5, 8'h00, 1'b1, 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, 2'd2, 8'h01, 1'b1};
    vecs[1]  = '{8'h9E, 0, 8'h01, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'hFF, 1'b1};
    vecs[2]  = '{8'hC0, 1, 8'hFF, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1};
    vecs[3]  = '{8'hB5, 2, 8'h00, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h15, 1'b1};
    vecs[4]  = '{8'h0F, 0, 8'h15, 1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 1'b1, 2'd3, 8'h16, 1'b0};
    vecs[5]  = '{8'h4B, 1, 8'h16, 1'b1, 1'b1, 2'd2, 2'd1, 2'd1, 1'b1, 2'd1, 8'h17, 1'b1};
    vecs[6]  = '{8'h80, 0, 8'h17, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h17, 1'b1};
    vecs[7]  = '{8'h2C, 2, 8'h17, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 2'd2, 8'h18, 1'b0};
    vecs[8]  = '{8'h85, 0, 8'h18, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h19, 1'b0};
    vecs[9]  = '{8'h60, 1, 8'h19, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h1A, 1'b0};
    vecs[10] = '{8'h16, 0, 8'h1A, 1'b1, 1'b1, 2'd0, 2'd2, 2'd3, 1'b0, 2'd3, 8'h1B, 1'b1};
    vecs[11] = '{8'h8F, 3, 8'h1B, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h2A, 1'b1};
    vecs[12] = '{8'h7F, 0, 8'h2A, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h2B, 1'b1};

    // Reset with a stray valid carrying HALT: must be ignored.
    rst_n_i      = 1'b0;
    imem_valid_i = 1'b1;
    imem_data_i  = 8'hE0;
    alu_zero_i   = 1'b1;
    step();
    step();
    chk("rst_req", int'(imem_req_o), 0);
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_z", int'(z_flag_o), 0);
    chk("rst_halt", int'(halted_o), 0);
    chk("rst_op", int'(alu_op_o), 3);
    chk("rst_we", int'(rf_we_o), 0);
    rst_n_i = 1'b1;
    step();
    imem_valid_i = 1'b0;
    imem_data_i  = 8'h00;
    alu_zero_i   = 1'b0;
    chk("rel_req", int'(imem_req_o), 1);
    chk("rel_halt", int'(halted_o), 0);
    chk("rel_pc", int'(pc_o), 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset during WB of NAND: no write follows, z cleared, pc back to reset.
    fetch(8'h4B, 0, 8'h2B);
    step();
    chk("nwb_we", int'(rf_we_o), 1);
    chk("nwb_z", int'(z_flag_o), 1);
    rst_n_i    = 1'b0;
    alu_zero_i = 1'b1;
    step();
    alu_zero_i = 1'b0;
    chk("nrst_we", int'(rf_we_o), 0);
    chk("nrst_z", int'(z_flag_o), 0);
    chk("nrst_pc", int'(pc_o), 0);
    chk("nrst_req", int'(imem_req_o), 0);
    chk("nrst_op", int'(alu_op_o), 3);
    rst_n_i = 1'b1;
    step();
    chk("nrel_req", int'(imem_req_o), 1);

    // JMP to 0x1F, then HALT there with stray valids.
    v = '{8'hBF, 0, 8'h00, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 8'h1F, 1'b0};
    run_vec(v);
    fetch(8'hE0, 1, 8'h1F);
    chk("hexec_halt", int'(halted_o), 0);
    step();
    imem_valid_i = 1'b1;
    imem_data_i  = 8'h0F;
    for (int k = 0; k < 10; k++) begin
      chk("halt_halted", int'(halted_o), 1);
      chk("halt_req", int'(imem_req_o), 0);
      chk("halt_op", int'(alu_op_o), 3);
      chk("halt_pc", int'(pc_o), 8'h1F);
      step();
    end
    rst_n_i = 1'b0;
    step();
    chk("hrst_halt", int'(halted_o), 0);
    chk("hrst_pc", int'(pc_o), 0);
    chk("hrst_req", int'(imem_req_o), 0);
    rst_n_i = 1'b1;
    step();
    imem_valid_i = 1'b0;
    imem_data_i  = 8'h00;
    chk("hrel_req", int'(imem_req_o), 1);

    // Fetch resumes: ADD r1, imm2=3 at reset pc.
    v = '{8'h0F, 2, 8'h00, 1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 1'b1, 2'd3, 8'h01, 1'b0};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle control unit that drives the 8-bit ALU and register file from a fetched instruction stream.
- Fetches 8-bit instructions over a req/valid handshake and decodes them.
- Issues ALU op, immediate and register-select controls, and writes the ALU result back.
- Consumes the ALU zero flag for the conditional branch. It sits between instruction memory, the 4-entry register file and the ALU.

Parameters:
- PC_W, 8, program counter and imem address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; one clock, synchronous reset, sampled on rising clk.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_valid  in  1  fetch data valid.
- imem_data  in  8  instruction word.
- rf_raddr1  out  2  register read select feeding ALU src1.
- rf_raddr2  out  2  register read select feeding ALU src2.
- rf_we  out  1  register write enable.
- rf_waddr  out  2  register write select.
- alu_op  out  2  00 ADD, 01 SUB, 10 NAND, 11 NULL (ALU holds result and zero flag).
- imm_sel  out  1  1 = ALU uses imm2, 0 = uses src2.
- imm2  out  2  immediate to ALU.
- alu_zero  in  1  ALU zero flag.
- pc  out  PC_W  current program counter.
- z_flag  out  1  latched zero flag used by BZ.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction format: op[7:5], rd[4:3], rs/imm2[2:1], i[0]. BZ and JMP use ir[4:0] as target/offset.
- Opcodes:
  - 000 ADD, 001 SUB, 010 NAND: rd <= rd op (i ? zext(imm2) : rs).
  - 011 NOP (reserved).
  - 100 BZ: pc <= pc + sext5(ir[4:0]) if z_flag, else pc+1.
  - 101 JMP: pc <= zext(ir[4:0]).
  - 110 NOP.
  - 111 HALT.
- States:
  - FETCH: imem_req=1, imem_addr=pc. When imem_valid=1, ir <= imem_data and go to EXEC. imem_req stays high until then; the wait is unbounded.
  - EXEC, ALU op: alu_op=op[1:0], rf_raddr1=rd, rf_raddr2=rs field, imm_sel=i, imm2=ir[2:1]; go to WB.
  - EXEC, BZ/JMP/NOP: update pc as above; go to FETCH. No ALU activity, alu_op=11.
  - EXEC, HALT: go to HALT; pc unchanged.
  - WB: same ALU controls held as in EXEC. rf_we=1, rf_waddr=rd. z_flag <= alu_zero; pc <= pc+1; go to FETCH.
  - HALT: all strobes low, alu_op=11, halted=1. Stays until reset; imem_valid is ignored.
- Outside EXEC/WB:
  - alu_op=11, imm_sel=0, imm2=0, rf_we=0.
  - rf_raddr1/2 and rf_waddr=0.
- Latency: an ALU instruction takes fetch wait + 3 cycles (FETCH accept, EXEC, WB). Branch/NOP take fetch wait + 2.
- Reset (rst_n=0 at a clk edge):
  - state=FETCH, pc=RESET_PC, ir=0, z_flag=0, halted=0.
  - imem_req=0 during the reset cycle; all ALU/RF controls at their idle values above.
  - Fetch begins the first cycle rst_n is high.
  - A fetch in flight is abandoned; imem_valid in the reset cycle is ignored.
- imem_valid while imem_req=0 is ignored.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 wraps to 0x00; BZ offset wraps both directions.
- z_flag changes only in WB of ADD/SUB/NAND. BZ/JMP/NOP/HALT preserve it.
- Branch with z_flag=1 and offset 0 loops on itself, which is legal.

Test Plan:
- Reset then ADD with i=1 (0x0F = ADD r1,imm2=3), r1=5 → EXEC controls: alu_op=00, imm_sel=1, imm2=3, rf_raddr1=1. WB: rf_we=1, rf_waddr=1, z_flag=0, pc 0→1.
- SUB r2,r2 (0x34), i=0, r2=0x7A → alu_op=01, rf_raddr1=rf_raddr2=2, z_flag=1 after WB. A following BZ -2 (0x9E) at pc=1 → pc=0xFF.
- imem_valid withheld 5 cycles in FETCH → imem_req held high and imem_addr stable. A stray imem_valid in HALT or during reset → no state change.
- pc=0xFF with NOP (0xC0) → pc wraps to 0x00. JMP 0x15 (0xB5) → pc=0x15. z_flag unchanged across both.
- HALT (0xE0) → halted=1 next cycle, alu_op=11, imem_req=0 for 10 cycles. rst_n low for 1 cycle → pc=RESET_PC, halted=0, fetch resumes.
- rst_n asserted during WB of NAND → no further rf_we, z_flag=0, pc=RESET_PC on the next cycle.
